// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default timing for debounce_pulse_gen.
//   state_t        : debounce FSM state encoding
//   DEF_SYNC_STAGES, DEF_STABLE_CYCLES, DEF_REPEAT_CYCLES : default parameters
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_REPEAT_CYCLES = 6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for a single asynchronous bit.
//   clk     : sampling clock
//   reset_n : synchronous active-low reset, clears every stage
//   d       : asynchronous input
//   q       : synchronised output (last stage)
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen: synchronises and debounces a raw button, producing a
// clean level and a one-clock press pulse for a counter enable.
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   btn_in     : raw asynchronous button, active high
//   level_out  : debounced registered level
//   enable_out : registered one-cycle pulse per accepted press
// Optional: define DEBOUNCE_AUTOREPEAT_EN to emit a repeat pulse every
// REPEAT_CYCLES clocks while the button stays held.
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic level_out,
  output logic enable_out
);

  localparam int CNT_MAX = max2(STABLE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             w_sync_q;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_level, w_level_nxt;
  logic             r_en, w_en_nxt;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_in),
    .q       (w_sync_q)
  );

  // saturating increment, never wraps
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_sync_q) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_sync_q) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      IDLE_HIGH: begin
        if (!w_sync_q) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_ONE;
        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
          if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            w_en_nxt  = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
`else
          w_cnt_nxt = '0;
`endif
        end
      end
      WAIT_LOW: begin
        if (w_sync_q) begin
          // bounce back to held: repeat timing restarts from zero
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // level follows the stable side of the next state, so it changes on the
  // same edge the qualification completes
  assign w_level_nxt = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_en    <= w_en_nxt;
    end
  end

  assign level_out  = r_level;
  assign enable_out = r_en;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
module tb_debounce_pulse_gen;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int REPEAT = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_in = 1'b1;
  logic level_out, enable_out;

  int n_chk = 0;
  int n_err = 0;
  int edges_done = 0;
  int n_pulse = 0;

  debounce_pulse_gen #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (btn_in),
    .level_out (level_out),
    .enable_out(enable_out)
  );

  always #5 clk = ~clk;

  // Reference model: sync_q is btn_in delayed SYNC edges; the level flips
  // after STABLE consecutive samples that disagree with it.
  bit dly [SYNC];
  bit m_level = 1'b0;
  bit m_en = 1'b0;
  int run = 0;
  int hold = 0;

  always @(posedge clk) begin
    edges_done++;
    if (!reset_n) begin
      for (int i = 0; i < SYNC; i++) dly[i] = 1'b0;
      m_level = 1'b0; m_en = 1'b0; run = 0; hold = 0;
    end else begin
      bit s;
      s = dly[SYNC-1];
      m_en = 1'b0;
      if (s != m_level) begin
        hold = 0;
        run++;
        if (run == STABLE) begin
          m_level = s;
          run = 0;
          m_en = s;
        end
      end else if (run != 0) begin
        run = 0;
        hold = 0;
      end else if (m_level) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
        hold++;
        if (hold == REPEAT) begin
          m_en = 1'b1;
          hold = 0;
        end
`endif
      end
      for (int i = SYNC-1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = btn_in;
    end
  end

  // per-cycle comparison against the model
  bit prev_en = 1'b0;
  always @(negedge clk) begin
    if (edges_done > 0) begin
      n_chk++;
      if (level_out !== m_level) begin
        n_err++;
        $display("FAIL model_level edge=%0d got=%b want=%b", edges_done-1, level_out, m_level);
      end
      n_chk++;
      if (enable_out !== m_en) begin
        n_err++;
        $display("FAIL model_en edge=%0d got=%b want=%b", edges_done-1, enable_out, m_en);
      end
      n_chk++;
      if (enable_out === 1'b1 && prev_en) begin
        n_err++;
        $display("FAIL en_back_to_back edge=%0d got=1 want=0", edges_done-1);
      end
      prev_en = (enable_out === 1'b1);
      if (enable_out === 1'b1) n_pulse++;
    end
  end

  task automatic at_edge(input int k);
    while (edges_done <= k) @(negedge clk);
  endtask

  task automatic set_btn(input int e, input logic v);
    at_edge(e - 1);
    btn_in = v;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic lit(input int e, input string nm, input logic lv, input logic en);
    at_edge(e);
    chk({nm, "_level"}, level_out, lv);
    chk({nm, "_en"}, enable_out, en);
  endtask

  task automatic lit_lvl(input int e, input string nm, input logic lv);
    at_edge(e);
    chk({nm, "_level"}, level_out, lv);
  endtask

  task automatic snap(input int e, output int v);
    at_edge(e);
    #1;
    v = n_pulse;
  endtask

  task automatic chk_cnt(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  int p0, p1;

  initial begin
    // 1: reset held for edges 0..2 with button already high
    lit(0, "rst0", 1'b0, 1'b0);
    lit(2, "rst2", 1'b0, 1'b0);
    reset_n = 1'b1;
    lit(7, "pwr_pre", 1'b0, 1'b0);
    lit(8, "pwr_pulse", 1'b1, 1'b1);
    lit(9, "pwr_post", 1'b1, 1'b0);

    // 5: short release rejected, then real release
    set_btn(12, 1'b0);
    set_btn(15, 1'b1);
    lit_lvl(20, "rel_glitch", 1'b1);
    set_btn(25, 1'b0);
    lit_lvl(29, "rel_pre", 1'b1);
    lit_lvl(30, "rel_fall", 1'b0);

    // 2: clean press
    snap(39, p0);
    set_btn(40, 1'b1);
    lit(44, "press_pre", 1'b0, 1'b0);
    lit(45, "press_pulse", 1'b1, 1'b1);
    lit(46, "press_post", 1'b1, 1'b0);
    snap(59, p1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    chk_cnt("press_count", p1 - p0, 3);
`else
    chk_cnt("press_count", p1 - p0, 1);
`endif
    btn_in = 1'b0;
    lit_lvl(64, "press_rel_pre", 1'b1);
    lit_lvl(65, "press_rel_fall", 1'b0);

    // 3: three-sample glitch
    snap(69, p0);
    btn_in = 1'b1;
    set_btn(73, 1'b0);
    lit(90, "glitch", 1'b0, 1'b0);
    snap(95, p1);
    chk_cnt("glitch_count", p1 - p0, 0);

    // 4: bounce 1,0,1,1,0,1 then held; last rise sampled at 105
    snap(99, p0);
    btn_in = 1'b1;
    set_btn(101, 1'b0);
    set_btn(102, 1'b1);
    set_btn(104, 1'b0);
    set_btn(105, 1'b1);
    lit(109, "bounce_pre", 1'b0, 1'b0);
    lit(110, "bounce_pulse", 1'b1, 1'b1);
    lit(111, "bounce_post", 1'b1, 1'b0);
    snap(125, p1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    chk_cnt("bounce_count", p1 - p0, 3);
`else
    chk_cnt("bounce_count", p1 - p0, 1);
`endif
    btn_in = 1'b0;
    lit_lvl(130, "bounce_rel_pre", 1'b1);
    lit_lvl(131, "bounce_rel_fall", 1'b0);

    // 6: long hold (repeat pulses when enabled), then reset mid-hold
    set_btn(140, 1'b1);
    lit(145, "hold_pulse", 1'b1, 1'b1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    lit(150, "rep_pre", 1'b1, 1'b0);
    lit(151, "rep1", 1'b1, 1'b1);
    lit(152, "rep1_post", 1'b1, 1'b0);
    lit(157, "rep2", 1'b1, 1'b1);
`else
    lit(151, "norep", 1'b1, 1'b0);
    lit(157, "norep2", 1'b1, 1'b0);
`endif
    at_edge(170);
    reset_n = 1'b0;
    lit(171, "midrst", 1'b0, 1'b0);
    btn_in = 1'b0;
    at_edge(172);
    reset_n = 1'b1;
    lit(180, "after_rst", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
